// File: rtl/audio_in_deser.sv
// audio_in_deser: I2S / left-justified ADC capture. Oversamples BCLK, LRCLK and
// ADCDAT in the clk domain, rebuilds the left/right words MSB first and hands
// the stereo pair downstream over a valid/ready handshake.
// Optional peak tracking is built only when AUDIO_IN_PEAK_EN is defined.
`timescale 1ns/1ps
module audio_in_deser #(
  parameter int WIDTH       = 16,
  parameter int DELAY_BITS  = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             BCLK,
  input  logic             LRCLK,
  input  logic             ADCDAT,
  input  logic             out_ready,
  input  logic             clr_err,
  output logic [WIDTH-1:0] left,
  output logic [WIDTH-1:0] right,
  output logic             out_valid,
  output logic             overrun,
  output logic             frame_err,
  output logic [WIDTH-1:0] peak_l,
  output logic [WIDTH-1:0] peak_r
);

  localparam int POS_MAX_I = DELAY_BITS + WIDTH;
  localparam int POS_W     = $clog2(POS_MAX_I + 1);
  localparam logic [POS_W-1:0] POS_MAX   = POS_W'(POS_MAX_I);
  localparam logic [POS_W-1:0] POS_FIRST = POS_W'(DELAY_BITS);
  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(POS_MAX_I - 1);
  localparam logic [POS_W-1:0] POS_WID   = POS_W'(WIDTH);

  typedef enum logic [1:0] {IDLE, WAIT_L, CAP_L, CAP_R} state_t;

  logic [SYNC_STAGES-1:0] bclk_sync, lr_sync, dat_sync;
  logic                   bclk_prev;
  logic                   bclk_s, lr_s, dat_s, rise;

  state_t           state;
  logic             lr_prev, lr_seen;
  logic [POS_W-1:0] pos, pos_next;
  logic             boundary, capture, full;
  logic [WIDTH-1:0] shift, left_hold, emit_l, emit_r;
  logic             emit;

  assign bclk_s = bclk_sync[SYNC_STAGES-1];
  assign lr_s   = lr_sync[SYNC_STAGES-1];
  assign dat_s  = dat_sync[SYNC_STAGES-1];
  assign rise   = bclk_s & ~bclk_prev;

  // Input synchronizers and BCLK edge history.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours; blocking here would collapse the chain.
    if (reset) begin
      bclk_sync <= '0;
      lr_sync   <= '0;
      dat_sync  <= '0;
      bclk_prev <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], BCLK};
      lr_sync   <= {lr_sync[SYNC_STAGES-2:0], LRCLK};
      dat_sync  <= {dat_sync[SYNC_STAGES-2:0], ADCDAT};
      bclk_prev <= bclk_s;
    end
  end

  // Half-frame position tracking and capture window decode.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    pos_next = pos;
    boundary = rise && lr_seen && (lr_s != lr_prev);
    if (boundary) begin
      pos_next = '0;
    end else if (pos != POS_MAX) begin
      pos_next = pos + POS_W'(1);
    end
    // Wraps below POS_FIRST to a large value, so one compare covers both ends.
    capture = rise && ((pos_next - POS_FIRST) < POS_WID);
    full    = (pos >= POS_LAST);
  end

  // Capture FSM: assembles words, validates half-frame length, emits pairs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lr_prev   <= 1'b0;
      lr_seen   <= 1'b0;
      pos       <= '0;
      shift     <= '0;
      left_hold <= '0;
      emit      <= 1'b0;
      emit_l    <= '0;
      emit_r    <= '0;
      frame_err <= 1'b0;
    end else begin
      emit <= 1'b0;
      if (clr_err) frame_err <= 1'b0;
      if (state == IDLE) state <= WAIT_L;
      if (rise) begin
        // The first rise after reset only seeds lr_prev so a mid-word reset
        // cannot fake a rising boundary.
        lr_prev <= lr_s;
        lr_seen <= 1'b1;
        pos     <= pos_next;
        if (capture) shift <= {shift[WIDTH-2:0], dat_s};
        if (boundary) begin
          case (state)
            WAIT_L: if (lr_s) state <= CAP_L;
            CAP_L: begin
              if (full) begin
                left_hold <= shift;
                state     <= CAP_R;
              end else begin
                frame_err <= 1'b1;
                state     <= lr_s ? CAP_L : WAIT_L;
              end
            end
            CAP_R: begin
              if (full) begin
                emit   <= 1'b1;
                emit_l <= left_hold;
                emit_r <= shift;
              end else begin
                frame_err <= 1'b1;
              end
              state <= CAP_L;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Output pair register, valid/ready handshake and overrun flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      left      <= '0;
      right     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (clr_err) overrun <= 1'b0;
      if (emit) begin
        left      <= emit_l;
        right     <= emit_r;
        out_valid <= 1'b1;
        if (out_valid && !out_ready) overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef AUDIO_IN_PEAK_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MOST_POS = ~MOST_NEG;

  logic pk_upd;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] s);
    if (!s[WIDTH-1]) return s;
    if (s == MOST_NEG) return MOST_POS;
    return -s;
  endfunction

  // Peak magnitude tracking, one clk after the pair reaches the outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pk_upd <= 1'b0;
      peak_l <= '0;
      peak_r <= '0;
    end else begin
      pk_upd <= emit;
      if (clr_err) begin
        peak_l <= '0;
        peak_r <= '0;
      end else if (pk_upd) begin
        if (mag(left) > peak_l)  peak_l <= mag(left);
        if (mag(right) > peak_r) peak_r <= mag(right);
      end
    end
  end
`else
  assign peak_l = '0;
  assign peak_r = '0;
`endif

endmodule

// File: tb/tb_audio_in_deser.sv
// tb_audio_in_deser: drives a behavioural I2S codec (BCLK = clk/8, 32 BCLK per
// half-frame, one-bit delay) and compares the received pairs, flags and peaks
// against expectations computed from the stimulus words.
`timescale 1ns/1ps
module tb_audio_in_deser;
  localparam int W = 16;

  logic clk = 1'b0, reset = 1'b1;
  logic BCLK = 1'b0, LRCLK = 1'b0, ADCDAT = 1'b0;
  logic out_ready = 1'b1, clr_err = 1'b0;
  logic [W-1:0] left, right, peak_l, peak_r;
  logic out_valid, overrun, frame_err;

  int checks = 0;
  int failures = 0;

  typedef struct packed {logic [W-1:0] l; logic [W-1:0] r;} pair_t;
  pair_t acc_q[$];
  int    vrise_cnt = 0;
  time   t_valid = 0;
  time   t_bound = 0;
  logic  ov_q = 1'b0;

  audio_in_deser #(.WIDTH(W), .DELAY_BITS(1), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .BCLK(BCLK), .LRCLK(LRCLK), .ADCDAT(ADCDAT),
    .out_ready(out_ready), .clr_err(clr_err), .left(left), .right(right),
    .out_valid(out_valid), .overrun(overrun), .frame_err(frame_err),
    .peak_l(peak_l), .peak_r(peak_r)
  );

  always #5 clk = ~clk;

  // Records out_valid rises and accepted pairs, sampled on the falling edge.
  always @(negedge clk) begin
    if (out_valid && !ov_q) begin
      vrise_cnt <= vrise_cnt + 1;
      t_valid   <= $time;
    end
    if (out_valid && out_ready) acc_q.push_back({left, right});
    ov_q <= out_valid;
  end

  // One BCLK period: data and LRCLK change on the falling edge.
  task automatic bclk_cycle(input logic lr, input logic d, input logic mark);
    BCLK = 1'b0; LRCLK = lr; ADCDAT = d;
    #40;
    BCLK = 1'b1;
    if (mark) t_bound = $time;
    #40;
  endtask

  // nb BCLKs of one half-frame; bit k of the word sits at BCLK W-k, the rest is noise.
  task automatic send_half(input logic lr, input logic [W-1:0] word, input int nb);
    for (int i = 0; i < nb; i++) begin
      logic d;
      if (i >= 1 && i <= W) d = word[W-i];
      else d = 1'($urandom_range(1, 0));
      bclk_cycle(lr, d, i == 0);
    end
  endtask

  task automatic send_pair(input logic [W-1:0] l, input logic [W-1:0] r);
    send_half(1'b1, l, 32);
    send_half(1'b0, r, 32);
  endtask

  // Start of the next left half supplies the boundary that emits the last pair.
  task automatic trailer();
    send_half(1'b1, 16'h0, 2);
    repeat (8) @(posedge clk);
  endtask

  // Leaves the codec phase 2 ns after a posedge for deterministic latency.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #7;
  endtask

  function automatic int mag_sat(input logic [W-1:0] v);
    int a;
    a = int'($signed(v));
    if (a < 0) a = -a;
    if (a > 32767) a = 32767;
    return a;
  endfunction

  task automatic test_reset();
    do_reset();
    checks++; if (left !== 16'h0) begin failures++; $display("FAIL reset_left got=%h exp=0000", left); end
    checks++; if (right !== 16'h0) begin failures++; $display("FAIL reset_right got=%h exp=0000", right); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if ({overrun, frame_err} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {overrun, frame_err}); end
    checks++; if ({peak_l, peak_r} !== 32'h0) begin failures++; $display("FAIL reset_peaks got=%h exp=0", {peak_l, peak_r}); end
  endtask

  task automatic test_basic();
    int base, vbase;
    time d;
    do_reset();
    out_ready = 1'b1;
    base = acc_q.size(); vbase = vrise_cnt;
    send_half(1'b0, 16'($urandom), 32);
    send_pair(16'h8001, 16'h7FFE);
    trailer();
    checks++; if (vrise_cnt - vbase !== 1) begin failures++; $display("FAIL basic_pulses got=%0d exp=1", vrise_cnt - vbase); end
    checks++;
    if (acc_q.size() - base !== 1) begin
      failures++; $display("FAIL basic_count got=%0d exp=1", acc_q.size() - base);
    end else if (acc_q[base] !== {16'h8001, 16'h7FFE}) begin
      failures++; $display("FAIL basic_pair got=%h exp=80017ffe", acc_q[base]);
    end
    checks++; if ({overrun, frame_err} !== 2'b00) begin failures++; $display("FAIL basic_flags got=%b exp=00", {overrun, frame_err}); end
    // out_valid must rise on the 4th clk posedge after the raw boundary edge,
    // observed at the following negedge.
    d = t_valid - t_bound;
    checks++; if (!(d > 35 && d <= 45)) begin failures++; $display("FAIL basic_latency got=%0t exp=36..45", d); end
  endtask

  task automatic test_overrun();
    int vbase;
    do_reset();
    out_ready = 1'b0;
    vbase = vrise_cnt;
    send_half(1'b0, 16'($urandom), 32);
    send_pair(16'h1234, 16'h5678);
    send_pair(16'h0ABC, 16'hFEDC);
    trailer();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%b exp=1", out_valid); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    checks++; if ({left, right} !== {16'h0ABC, 16'hFEDC}) begin failures++; $display("FAIL ovr_pair got=%h exp=0abcfedc", {left, right}); end
    checks++; if (vrise_cnt - vbase !== 1) begin failures++; $display("FAIL ovr_pulses got=%0d exp=1", vrise_cnt - vbase); end
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ovr_hold got=%b exp=1", out_valid); end
    out_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovr_accept got=%b exp=0", out_valid); end
  endtask

  task automatic test_short_frame();
    int base;
    do_reset();
    out_ready = 1'b1;
    base = acc_q.size();
    send_half(1'b0, 16'($urandom), 32);
    send_half(1'b1, 16'($urandom), 10);
    send_half(1'b0, 16'($urandom), 32);
    send_pair(16'h1111, 16'h2222);
    trailer();
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL short_err got=%b exp=1", frame_err); end
    checks++;
    if (acc_q.size() - base !== 1) begin
      failures++; $display("FAIL short_count got=%0d exp=1", acc_q.size() - base);
    end else if (acc_q[base] !== {16'h1111, 16'h2222}) begin
      failures++; $display("FAIL short_pair got=%h exp=11112222", acc_q[base]);
    end
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL short_clear got=%b exp=0", frame_err); end
  endtask

  task automatic test_mid_right();
    int base;
    pair_t p;
    do_reset();
    out_ready = 1'b1;
    base = acc_q.size();
    p.l = 16'($urandom); p.r = 16'($urandom);
    send_half(1'b0, 16'($urandom), 13);
    send_pair(p.l, p.r);
    trailer();
    checks++;
    if (acc_q.size() - base !== 1) begin
      failures++; $display("FAIL mid_count got=%0d exp=1", acc_q.size() - base);
    end else if (acc_q[base] !== p) begin
      failures++; $display("FAIL mid_pair got=%h exp=%h", acc_q[base], p);
    end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL mid_err got=%b exp=0", frame_err); end
  endtask

  task automatic test_reset_mid_word();
    int base;
    pair_t p;
    do_reset();
    out_ready = 1'b0;
    p.l = 16'($urandom) | 16'h0001; p.r = 16'($urandom);
    send_half(1'b0, 16'($urandom), 32);
    send_pair(p.l, p.r);
    send_half(1'b1, 16'($urandom), 8);
    checks++; if ({out_valid, left} !== {1'b1, p.l}) begin failures++; $display("FAIL rmid_pre got=%h exp=%h", {out_valid, left}, {1'b1, p.l}); end
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({left, right, out_valid, overrun, frame_err} !== '0) begin
      failures++; $display("FAIL rmid_zero got=%h exp=0", {left, right, out_valid, overrun, frame_err});
    end
    reset = 1'b0; #7;
    out_ready = 1'b1;
    base = acc_q.size();
    send_half(1'b1, 16'($urandom), 24);
    send_half(1'b0, 16'($urandom), 32);
    send_pair(16'h00FF, 16'hFF00);
    trailer();
    checks++;
    if (acc_q.size() - base !== 1) begin
      failures++; $display("FAIL rmid_count got=%0d exp=1", acc_q.size() - base);
    end else if (acc_q[base] !== {16'h00FF, 16'hFF00}) begin
      failures++; $display("FAIL rmid_pair got=%h exp=00ffff00", acc_q[base]);
    end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL rmid_err got=%b exp=0", frame_err); end
  endtask

  task automatic test_back_to_back();
    int base;
    pair_t exp_q[$];
    do_reset();
    out_ready = 1'b1;
    base = acc_q.size();
    send_half(1'b0, 16'($urandom), 32);
    for (int k = 0; k < 6; k++) begin
      pair_t p;
      p.l = 16'($urandom); p.r = 16'($urandom);
      exp_q.push_back(p);
      send_pair(p.l, p.r);
    end
    trailer();
    checks++;
    if (acc_q.size() - base !== exp_q.size()) begin
      failures++; $display("FAIL b2b_count got=%0d exp=%0d", acc_q.size() - base, exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (acc_q[base+k] !== exp_q[k]) begin
          failures++; $display("FAIL b2b_pair%0d got=%h exp=%h", k, acc_q[base+k], exp_q[k]);
        end
      end
    end
    checks++; if ({overrun, frame_err} !== 2'b00) begin failures++; $display("FAIL b2b_flags got=%b exp=00", {overrun, frame_err}); end
  endtask

  task automatic test_peak();
    logic [W-1:0] ls[2], rs[2];
    int exp_l, exp_r;
    do_reset();
    out_ready = 1'b1;
    ls[0] = 16'h8000; rs[0] = 16'd100;
    ls[1] = 16'd5;    rs[1] = 16'hFF38;
    exp_l = 0; exp_r = 0;
    send_half(1'b0, 16'($urandom), 32);
    for (int k = 0; k < 2; k++) begin
      send_pair(ls[k], rs[k]);
      if (mag_sat(ls[k]) > exp_l) exp_l = mag_sat(ls[k]);
      if (mag_sat(rs[k]) > exp_r) exp_r = mag_sat(rs[k]);
    end
    trailer();
`ifndef AUDIO_IN_PEAK_EN
    exp_l = 0; exp_r = 0;
`endif
    checks++; if (peak_l !== 16'(exp_l)) begin failures++; $display("FAIL peak_l got=%0d exp=%0d", peak_l, exp_l); end
    checks++; if (peak_r !== 16'(exp_r)) begin failures++; $display("FAIL peak_r got=%0d exp=%0d", peak_r, exp_r); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_short_frame();
    test_mid_right();
    test_reset_mid_word();
    test_back_to_back();
    test_peak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
